// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline: data/register widths, the
// writeback FSM states and the hard-wired zero register index.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback.sv
// Final pipeline stage: picks the destination and result source, waits for
// late load data (with a timeout), and drives a registered register-file write.
module writeback #(
  parameter int DATA_W      = mips_pkg::DATA_W,
  parameter int REG_AW      = mips_pkg::REG_AW,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [REG_AW-1:0] ins1,
  input  logic [REG_AW-1:0] ins2,
  input  logic              regDst,
  input  logic              memToReg,
  input  logic              regWriteIn,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] memData,
  input  logic              memValid,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  output logic              busy,
  output logic              timeoutErr
);

  import mips_pkg::*;

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  wb_state_t         state;
  logic [7:0]        waitCnt;
  logic [REG_AW-1:0] pendReg;
  logic              pendWen;
  logic [REG_AW-1:0] dst;
  logic              wen;

  assign dst     = regDst ? ins2 : ins1;
  assign wen     = regWriteIn && (dst != REG_AW'(REG_ZERO));
  assign inReady = (state == IDLE);
  assign busy    = (state != IDLE);

  // On the final wait cycle a returning load still wins over the abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      waitCnt    <= '0;
      pendReg    <= '0;
      pendWen    <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
      regWrite   <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            if (!memToReg) begin
              writeReg  <= dst;
              writeData <= aluResult;
              regWrite  <= wen;
            end else begin
              pendReg <= dst;
              pendWen <= wen;
              waitCnt <= '0;
              state   <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (memValid) begin
            writeReg  <= pendReg;
            writeData <= memData;
            regWrite  <= pendWen;
            state     <= IDLE;
          end else if (waitCnt == LAST_WAIT) begin
            timeoutErr <= 1'b1;
            state      <= IDLE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: a transaction-level model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_writeback;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [AW-1:0] ins1 = '0;
  logic [AW-1:0] ins2 = '0;
  logic          regDst = 1'b0;
  logic          memToReg = 1'b0;
  logic          regWriteIn = 1'b0;
  logic [DW-1:0] aluResult = '0;
  logic [DW-1:0] memData = '0;
  logic          memValid = 1'b0;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic          regWrite;
  logic          busy;
  logic          timeoutErr;

  int checks = 0;
  int failures = 0;

  writeback #(.DATA_W(DW), .REG_AW(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .ins1(ins1), .ins2(ins2), .regDst(regDst), .memToReg(memToReg),
    .regWriteIn(regWriteIn), .aluResult(aluResult), .memData(memData),
    .memValid(memValid), .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  // Reference model: a pending load is tracked by its age in edges since accept.
  bit            mPending = 1'b0;
  int            mAge = 0;
  logic [AW-1:0] mPendReg = '0;
  bit            mPendWen = 1'b0;
  bit            mWrite = 1'b0;
  logic [AW-1:0] mReg = '0;
  logic [DW-1:0] mData = '0;
  bit            mErr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [AW-1:0] d;
    if (!rst_n) begin
      mPending = 1'b0; mAge = 0; mPendReg = '0; mPendWen = 1'b0;
      mWrite = 1'b0; mReg = '0; mData = '0; mErr = 1'b0;
    end else begin
      mWrite = 1'b0;
      if (!mPending) begin
        if (inValid) begin
          d = regDst ? ins2 : ins1;
          if (!memToReg) begin
            mWrite = regWriteIn && (d != 0);
            mReg = d;
            mData = aluResult;
          end else begin
            mPending = 1'b1; mAge = 0; mPendReg = d;
            mPendWen = regWriteIn && (d != 0);
          end
        end
      end else begin
        mAge = mAge + 1;
        if (memValid) begin
          mWrite = mPendWen; mReg = mPendReg; mData = memData; mPending = 1'b0;
        end else if (mAge == TMO) begin
          mErr = 1'b1; mPending = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model.inReady", 32'(inReady), 32'(!mPending));
    checkOutput("model.busy", 32'(busy), 32'(mPending));
    checkOutput("model.regWrite", 32'(regWrite), 32'(mWrite));
    checkOutput("model.writeReg", 32'(writeReg), 32'(mReg));
    checkOutput("model.writeData", writeData, mData);
    checkOutput("model.timeoutErr", 32'(timeoutErr), 32'(mErr));
  end

  task automatic applyStimulus(input logic v, input logic [AW-1:0] i1, input logic [AW-1:0] i2,
                               input logic rd, input logic m2r, input logic rw,
                               input logic [DW-1:0] alu, input logic mv, input logic [DW-1:0] md);
    inValid = v; ins1 = i1; ins2 = i2; regDst = rd; memToReg = m2r;
    regWriteIn = rw; aluResult = alu; memValid = mv; memData = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset.regWrite", 32'(regWrite), 32'd0);
    checkOutput("reset.writeReg", 32'(writeReg), 32'd0);
    checkOutput("reset.writeData", writeData, 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.timeoutErr", 32'(timeoutErr), 32'd0);
    checkOutput("reset.inReady", 32'(inReady), 32'd1);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    doReset();

    // ALU op to r5.
    applyStimulus(1, 5, 0, 0, 0, 1, 32'h1234, 0, 0);
    step();
    checkOutput("alu.regWrite", 32'(regWrite), 32'd1);
    checkOutput("alu.writeReg", 32'(writeReg), 32'd5);
    checkOutput("alu.writeData", writeData, 32'h1234);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("alu.pulseEnds", 32'(regWrite), 32'd0);
    checkOutput("alu.holdReg", 32'(writeReg), 32'd5);

    // Back-to-back via ins2.
    applyStimulus(1, 1, 3, 1, 0, 1, 32'hA, 0, 0);
    step();
    checkOutput("b2b.first.writeReg", 32'(writeReg), 32'd3);
    checkOutput("b2b.first.inReady", 32'(inReady), 32'd1);
    applyStimulus(1, 1, 4, 1, 0, 1, 32'hB, 0, 0);
    step();
    checkOutput("b2b.second.regWrite", 32'(regWrite), 32'd1);
    checkOutput("b2b.second.writeReg", 32'(writeReg), 32'd4);
    checkOutput("b2b.second.writeData", writeData, 32'hB);

    // Zero register write suppressed; regWriteIn=0 suppressed.
    applyStimulus(1, 0, 9, 0, 0, 1, 32'h55, 0, 0);
    step();
    checkOutput("zero.regWrite", 32'(regWrite), 32'd0);
    applyStimulus(1, 12, 0, 0, 0, 0, 32'h66, 0, 0);
    step();
    checkOutput("noWen.regWrite", 32'(regWrite), 32'd0);

    // memValid in IDLE is ignored.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    step();
    checkOutput("idleMemValid.regWrite", 32'(regWrite), 32'd0);

    // Load to r7 with data three cycles after accept; ALU op stalled behind it.
    applyStimulus(1, 7, 0, 0, 1, 1, 32'h1, 0, 0);
    step();
    checkOutput("load.busy", 32'(busy), 32'd1);
    checkOutput("load.inReady", 32'(inReady), 32'd0);
    applyStimulus(1, 9, 0, 0, 0, 1, 32'h99, 0, 0);
    step();
    checkOutput("load.wait.regWrite", 32'(regWrite), 32'd0);
    step();
    checkOutput("load.wait.inReady", 32'(inReady), 32'd0);
    applyStimulus(1, 9, 0, 0, 0, 1, 32'h99, 1, 32'hDEADBEEF);
    step();
    checkOutput("load.regWrite", 32'(regWrite), 32'd1);
    checkOutput("load.writeReg", 32'(writeReg), 32'd7);
    checkOutput("load.writeData", writeData, 32'hDEADBEEF);
    applyStimulus(1, 9, 0, 0, 0, 1, 32'h99, 0, 0);
    step();
    checkOutput("stalled.writeReg", 32'(writeReg), 32'd9);
    checkOutput("stalled.writeData", writeData, 32'h99);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Timeout with no memValid.
    applyStimulus(1, 6, 0, 0, 1, 1, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) step();
    checkOutput("tmo.stillBusy", 32'(busy), 32'd1);
    checkOutput("tmo.noErrYet", 32'(timeoutErr), 32'd0);
    step();
    checkOutput("tmo.err", 32'(timeoutErr), 32'd1);
    checkOutput("tmo.idle", 32'(busy), 32'd0);
    checkOutput("tmo.noWrite", 32'(regWrite), 32'd0);
    checkOutput("tmo.holdReg", 32'(writeReg), 32'd9);
    step();
    checkOutput("tmo.sticky", 32'(timeoutErr), 32'd1);

    // Data arriving on the final edge wins over the abort.
    doReset();
    applyStimulus(1, 8, 0, 0, 1, 1, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
    step();
    checkOutput("lastEdge.regWrite", 32'(regWrite), 32'd1);
    checkOutput("lastEdge.writeReg", 32'(writeReg), 32'd8);
    checkOutput("lastEdge.writeData", writeData, 32'hCAFEF00D);
    checkOutput("lastEdge.noErr", 32'(timeoutErr), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset in the middle of a load wait drops the load.
    applyStimulus(1, 10, 0, 0, 1, 1, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("midRst.busyBefore", 32'(busy), 32'd1);
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    step();
    checkOutput("midRst.noWrite", 32'(regWrite), 32'd0);
    checkOutput("midRst.idle", 32'(busy), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
